// File: rtl/delay_line_pkg.sv
// Shared definitions for the delay_line fixed-latency pipeline.
// Optional checks are compiled in with the DELAY_LINE_ASSERT_EN macro.
package delay_line_pkg;

  localparam int DELAY_LINE_DEFAULT_WIDTH = 1;
  localparam int DELAY_LINE_DEFAULT_DELAY = 1;

  localparam string MSG_BAD_WIDTH = "delay_line: WIDTH must be >= 1";
  localparam string MSG_BAD_DELAY = "delay_line: DELAY must be >= 0";
  localparam string MSG_X_DIN     = "delay_line: din has X/Z while rst_n=1";
  localparam string MSG_LATENCY   = "delay_line: dout does not match din from DELAY cycles earlier";

  // Number of register stages to build; zero means a pure wire bypass.
  function automatic int delay_line_stages(input int delay);
    return (delay > 0) ? delay : 0;
  endfunction

endpackage : delay_line_pkg

// File: rtl/delay_line_stage.sv
// One WIDTH-bit pipeline register with synchronous active-low clear.
module delay_line_stage
  import delay_line_pkg::*;
#(
  parameter int WIDTH = DELAY_LINE_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  // Capture the previous tap each edge; clear wins over capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule : delay_line_stage

// File: rtl/delay_line.sv
// Fixed-latency shift chain: dout is din delayed by DELAY clk cycles.
// DELAY=0 collapses to a wire. Defining DELAY_LINE_ASSERT_EN adds
// parameter checks and simulation assertions without changing the logic.
module delay_line
  import delay_line_pkg::*;
#(
  parameter int WIDTH = DELAY_LINE_DEFAULT_WIDTH,
  parameter int DELAY = DELAY_LINE_DEFAULT_DELAY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int N_STAGES = delay_line_stages(DELAY);

`ifdef DELAY_LINE_ASSERT_EN
  if (WIDTH < 1) begin : g_bad_width
    $error("%s", MSG_BAD_WIDTH);
  end
  if (DELAY < 0) begin : g_bad_delay
    $error("%s", MSG_BAD_DELAY);
  end
`endif

  if (N_STAGES == 0) begin : g_bypass
    // Clock and reset are intentionally unused in the bypass build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign dout = din;
  end else begin : g_chain
    // tap[0] is the input, tap[k+1] the output of stage k.
    logic [WIDTH-1:0] tap [N_STAGES+1];
    assign tap[0] = din;

    for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
      delay_line_stage #(.WIDTH(WIDTH)) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (tap[k]),
        .q_o   (tap[k+1])
      );
    end

    assign dout = tap[N_STAGES];

`ifdef DELAY_LINE_ASSERT_EN
    int fill_q;

    // Count clean edges since reset; the latency check waits for a full refill.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        fill_q <= 0;
      end else if (fill_q < N_STAGES) begin
        fill_q <= fill_q + 1;
      end
    end

    a_latency: assert property (@(posedge clk)
      (fill_q == N_STAGES) |-> (dout == $past(din, N_STAGES)))
      else $error("%s", MSG_LATENCY);
`endif
  end

`ifdef DELAY_LINE_ASSERT_EN
  a_din_known: assert property (@(posedge clk) rst_n |-> !$isunknown(din))
    else $error("%s", MSG_X_DIN);
`endif

endmodule : delay_line

// File: tb/tb_delay_line.sv
// Self-checking bench for delay_line: four instances of different shapes,
// scoreboard queues for the registered ones, a vector table for the bypass.
module tb_delay_line;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, rst_c, rst_d;
  logic [9:0]  din_a, dout_a;
  logic [7:0]  din_b, dout_b;
  logic [15:0] din_c, dout_c;
  logic [0:0]  din_d, dout_d;

  delay_line #(.WIDTH(10), .DELAY(4)) u_a (.clk(clk), .rst_n(rst_a), .din(din_a), .dout(dout_a));
  delay_line #(.WIDTH(8),  .DELAY(3)) u_b (.clk(clk), .rst_n(rst_b), .din(din_b), .dout(dout_b));
  delay_line #(.WIDTH(16), .DELAY(0)) u_c (.clk(clk), .rst_n(rst_c), .din(din_c), .dout(dout_c));
  delay_line #(.WIDTH(1),  .DELAY(1)) u_d (.clk(clk), .rst_n(rst_d), .din(din_d), .dout(dout_d));

  int n_vec = 0;
  int n_err = 0;

  // Words still to emerge from each registered instance, oldest first.
  logic [15:0] sb_a[$], sb_b[$], sb_d[$];

  typedef struct {
    logic        rst_n;
    logic [15:0] din;
    logic [15:0] exp_dout;
  } vec_t;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Take one edge and check every registered instance against its scoreboard.
  // A reset edge clears the queue and preloads DELAY-1 zeros: the reset edge
  // itself shows zero, then DELAY-1 more zeros before the first captured word.
  task automatic step();
    @(posedge clk);
    #1;
    if (!rst_a) begin
      sb_a.delete();
      repeat (3) sb_a.push_back('0);
      cmp("a_rst", dout_a, '0);
    end else begin
      sb_a.push_back(16'(din_a));
      cmp("a_pipe", dout_a, sb_a.pop_front());
    end
    if (!rst_b) begin
      sb_b.delete();
      repeat (2) sb_b.push_back('0);
      cmp("b_rst", dout_b, '0);
    end else begin
      sb_b.push_back(16'(din_b));
      cmp("b_pipe", dout_b, sb_b.pop_front());
    end
    if (!rst_d) begin
      sb_d.delete();
      cmp("d_rst", dout_d, '0);
    end else begin
      sb_d.push_back(16'(din_d));
      cmp("d_pipe", dout_d, sb_d.pop_front());
    end
  endtask

  vec_t tbl_c [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl_c[0] = '{1'b1, 16'h1234, 16'h1234};
    tbl_c[1] = '{1'b1, 16'hBEEF, 16'hBEEF};
    tbl_c[2] = '{1'b0, 16'h1234, 16'h1234};
    tbl_c[3] = '{1'b0, 16'hBEEF, 16'hBEEF};
    tbl_c[4] = '{1'b1, 16'h0000, 16'h0000};
    tbl_c[5] = '{1'b0, 16'hFFFF, 16'hFFFF};

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b1; rst_d = 1'b0;
    din_a = '0; din_b = 8'hC3; din_c = '0; din_d = 1'b1;
    step();
    step();
    rst_a = 1'b1; rst_b = 1'b1; rst_d = 1'b1;

    // Counter into A, random into B, one-cycle pulse into D.
    for (int i = 0; i < 50; i++) begin
      din_a = 10'(i);
      din_b = 8'($urandom_range(0, 255));
      din_d = (i == 10) ? 1'b1 : 1'b0;
      step();
      if (i < 3)   cmp("a_postrst_zero", 16'(dout_a), 16'h0);
      if (i == 40) cmp("a_lat37", 16'(dout_a), 16'd37);
      if (i == 10) cmp("d_pulse_hi", 16'(dout_d), 16'd1);
      if (i == 11) cmp("d_pulse_lo", 16'(dout_d), 16'd0);
    end

    // B: fill, one-cycle reset, then fresh data; pre-reset words must vanish.
    din_b = 8'hA5; step();
    din_b = 8'h5A; step();
    din_b = 8'hFF; step();
    cmp("b_filled", 16'(dout_b), 16'h00A5);
    rst_b = 1'b0; din_b = 8'h77; step();
    cmp("b_rst_edge", 16'(dout_b), 16'h0000);
    rst_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din_b = 8'(8'h11 * (i + 1));
      step();
      if (i < 2)  cmp("b_refill_zero", 16'(dout_b), 16'h0000);
      if (i == 2) cmp("b_first_new", 16'(dout_b), 16'h0011);
    end

    // A: reset on the same edge as din=0x3FF; that word must never appear.
    din_a = 10'h155; step();
    din_a = 10'h3FF; rst_a = 1'b0; step();
    cmp("a_rst_same_edge", 16'(dout_a), 16'h0000);
    rst_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din_a = 10'(i + 1);
      step();
      if (i < 3) cmp("a_no_3ff", 16'(dout_a), 16'h0000);
    end

    // D: back-to-back pulses keep one-per-cycle throughput.
    for (int i = 0; i < 8; i++) begin
      din_d = 1'(i % 2);
      step();
    end

    // C: pure bypass, independent of rst_n and of the clock edge.
    foreach (tbl_c[i]) begin
      rst_c = tbl_c[i].rst_n;
      din_c = tbl_c[i].din;
      #1;
      cmp("c_comb", dout_c, tbl_c[i].exp_dout);
      step();
      cmp("c_after_edge", dout_c, tbl_c[i].exp_dout);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_delay_line
